adder_arbiter: RTL

Round-robin arbiter and sequencer that shares one fixed-latency 8-bit adder pipeline among NREQ requesters. Each requester submits an operand pair over a valid/ready handshake; the block issues at most one operation per cycle to the adder, tags it with the requester index, and returns the 9-bit sum to the correct requester when the result emerges. It sits between the client blocks and the shared sequential adder datapath.

---
 rtl/adder_arbiter.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter that shares one fixed-latency adder
// pipeline among NREQ requesters. Each accepted operation is tagged with
// its requester index, and the tag travels beside the adder so that the
// sum can be routed back to the right requester when it emerges.

// Protocol properties watched alongside the arbiter (ignored by synthesis).
module adder_arbiter_checker #(
  parameter int NREQ = 4
) (
  input logic            clk,
  input logic            rst,
  input logic [NREQ-1:0] req_ready,
  input logic [NREQ-1:0] resp_valid,
  input logic [NREQ-1:0] pending
);

  a_ready_onehot : assert property (@(posedge clk) disable iff (rst)
    $onehot0(req_ready));

  a_resp_onehot : assert property (@(posedge clk) disable iff (rst)
    $onehot0(resp_valid));

  a_no_grant_while_pending : assert property (@(posedge clk) disable iff (rst)
    (req_ready & pending) == {NREQ{1'b0}});

  a_resp_only_when_pending : assert property (@(posedge clk) disable iff (rst)
    (resp_valid & ~pending) == {NREQ{1'b0}});

endmodule

module adder_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int LAT  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   resp_valid,
  output logic [W:0]        resp_data,
  output logic [W-1:0]      add_a,
  output logic [W-1:0]      add_b,
  output logic              add_valid,
  input  logic [W:0]        add_result,
  output logic              busy
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef logic [IDXW-1:0] idx_t;

  // Index following idx, wrapping from NREQ-1 back to 0.
  function automatic idx_t f_next_idx(input idx_t idx);
    idx_t nxt;
    if (idx == idx_t'(NREQ - 1)) begin
      nxt = {IDXW{1'b0}};
    end else begin
      nxt = idx + idx_t'(1);
    end
    return nxt;
  endfunction

  // Round-robin pick: first eligible index after 'last'; returns {found, index}.
  function automatic logic [IDXW:0] f_rr_pick(input logic [NREQ-1:0] elig,
                                              input idx_t            last);
    idx_t cand;
    idx_t win;
    logic found;
    cand  = last;
    win   = {IDXW{1'b0}};
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = f_next_idx(cand);
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end else begin
        found = found;
        win   = win;
      end
    end
    return {found, win};
  endfunction

  // One-hot decode of a requester index.
  function automatic logic [NREQ-1:0] f_onehot(input idx_t idx);
    logic [NREQ-1:0] vec;
    vec = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      vec[i] = (idx == idx_t'(i));
    end
    return vec;
  endfunction

  // Select requester idx's W-bit lane out of a packed operand bus.
  function automatic logic [W-1:0] f_lane(input logic [NREQ*W-1:0] bus,
                                          input idx_t              idx);
    logic [W-1:0] lane;
    lane = {W{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (idx == idx_t'(i)) begin
        lane = bus[i*W +: W];
      end else begin
        lane = lane;
      end
    end
    return lane;
  endfunction

  // Arbitration state
  logic [NREQ-1:0] r_pending;
  idx_t            r_last;

  // Issue stage (drives the shared adder)
  logic            r_add_valid;
  logic [W-1:0]    r_add_a;
  logic [W-1:0]    r_add_b;
  idx_t            r_issue_idx;

  // Tag pipeline running in lockstep with the adder
  logic [LAT-1:0]  r_tag_valid;
  idx_t            r_tag_idx [LAT];

  // Response stage
  logic [NREQ-1:0] r_resp_valid;
  logic [W:0]      r_resp_data;

  // Combinational arbitration results
  logic [NREQ-1:0] w_eligible;
  logic [IDXW:0]   w_pick;
  idx_t            w_win;
  logic            w_grant;
  logic [NREQ-1:0] w_req_ready;

  // Pick the round-robin winner among requesters without an outstanding op.
  always_comb begin
    w_eligible  = req_valid & ~r_pending;
    w_pick      = f_rr_pick(w_eligible, r_last);
    w_win       = w_pick[IDXW-1:0];
    w_grant     = 1'b0;
    w_req_ready = {NREQ{1'b0}};
    if (!rst && w_pick[IDXW]) begin
      w_grant     = 1'b1;
      w_req_ready = f_onehot(w_win);
    end else begin
      w_grant     = 1'b0;
      w_req_ready = {NREQ{1'b0}};
    end
  end

  // Register the winner's operands toward the adder and advance the pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_add_valid <= 1'b0;
      r_add_a     <= {W{1'b0}};
      r_add_b     <= {W{1'b0}};
      r_issue_idx <= {IDXW{1'b0}};
      r_last      <= idx_t'(NREQ - 1);
    end else if (w_grant) begin
      r_add_valid <= 1'b1;
      r_add_a     <= f_lane(req_a, w_win);
      r_add_b     <= f_lane(req_b, w_win);
      r_issue_idx <= w_win;
      r_last      <= w_win;
    end else begin
      r_add_valid <= 1'b0;
      r_add_a     <= {W{1'b0}};
      r_add_b     <= {W{1'b0}};
      r_issue_idx <= {IDXW{1'b0}};
      r_last      <= r_last;
    end
  end

  // Track one outstanding op per requester: set on grant, clear after its response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= {NREQ{1'b0}};
    end else begin
      r_pending <= (r_pending & ~r_resp_valid) | w_req_ready;
    end
  end

  // Shift {valid, index} tags alongside the adder's internal pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_valid <= {LAT{1'b0}};
      for (int i = 0; i < LAT; i++) begin
        r_tag_idx[i] <= {IDXW{1'b0}};
      end
    end else begin
      r_tag_valid[0] <= r_add_valid;
      r_tag_idx[0]   <= r_issue_idx;
      for (int i = LAT - 1; i > 0; i--) begin
        r_tag_valid[i] <= r_tag_valid[i-1];
        r_tag_idx[i]   <= r_tag_idx[i-1];
      end
    end
  end

  // Capture the adder result for the requester whose tag is exiting now.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_valid <= {NREQ{1'b0}};
      r_resp_data  <= {(W+1){1'b0}};
    end else if (r_tag_valid[LAT-1]) begin
      r_resp_valid <= f_onehot(r_tag_idx[LAT-1]);
      r_resp_data  <= add_result;
    end else begin
      r_resp_valid <= {NREQ{1'b0}};
      r_resp_data  <= r_resp_data;
    end
  end

  assign req_ready  = w_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign add_a      = r_add_a;
  assign add_b      = r_add_b;
  assign add_valid  = r_add_valid;
  assign busy       = r_add_valid | (|r_tag_valid) | (|r_resp_valid) | (|r_pending);

  adder_arbiter_checker #(
    .NREQ (NREQ)
  ) u_checker (
    .clk        (clk),
    .rst        (rst),
    .req_ready  (w_req_ready),
    .resp_valid (r_resp_valid),
    .pending    (r_pending)
  );

endmodule
